// File: rtl/i3c_cmd_dispatch.sv
// i3c_cmd_dispatch
//   Takes one 64-bit TCRI command descriptor at a time from the HCI command
//   queue, decodes it by attribute, fetches the target's DAT entry and hands
//   the bus FSM a decoded transfer request with the resolved 7-bit address.
//   Commands that are rejected or completed here are answered directly with a
//   TCRI response descriptor.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   cmd_*                  command descriptor valid/ready handshake
//   dat_req_o/dat_addr_o   single-cycle DAT read request
//   dat_r*                 DAT read return (valid, data, error)
//   xfer_*                 decoded transfer request, held until xfer_ready_i
//   resp_*                 response descriptor, held until resp_ready_i
//   abort_i                drop the command in flight
//   idle_o                 FSM idle
//
// Every output is a flop or a decode of the state register; no input reaches
// an output combinationally.
module i3c_cmd_dispatch #(
  parameter int DatDepth = 16,
  parameter int DatWidth = 64,
  localparam int DatAw   = (DatDepth > 1) ? $clog2(DatDepth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [63:0]         cmd_desc_i,
  output logic                dat_req_o,
  output logic [DatAw-1:0]    dat_addr_o,
  input  logic                dat_rvalid_i,
  input  logic [DatWidth-1:0] dat_rdata_i,
  input  logic [1:0]          dat_rerror_i,
  output logic                xfer_valid_o,
  input  logic                xfer_ready_i,
  output logic [2:0]          xfer_attr_o,
  output logic [3:0]          xfer_tid_o,
  output logic [6:0]          xfer_addr_o,
  output logic                xfer_i2c_o,
  output logic                xfer_rnw_o,
  output logic [2:0]          xfer_mode_o,
  output logic                xfer_cp_o,
  output logic [7:0]          xfer_cmd_o,
  output logic [15:0]         xfer_len_o,
  output logic [31:0]         xfer_data_o,
  output logic                xfer_toc_o,
  output logic                xfer_wroc_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [31:0]         resp_desc_o,
  input  logic                abort_i,
  output logic                idle_o
);

  localparam logic [2:0] AttrRegular   = 3'd0;
  localparam logic [2:0] AttrImmediate = 3'd1;
  localparam logic [2:0] AttrAddrAssgn = 3'd2;
  localparam logic [2:0] AttrCombo     = 3'd3;
  localparam logic [2:0] AttrInternal  = 3'd7;

  localparam logic [3:0] MipiNoop      = 4'h0;

  localparam logic [3:0] ErrSuccess    = 4'h0;
  localparam logic [3:0] ErrNack       = 4'h5;
  localparam logic [3:0] ErrHcAborted  = 4'h8;
  localparam logic [3:0] ErrNotSupp    = 4'hA;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DAT_REQ  = 3'd1,
    DAT_WAIT = 3'd2,
    ISSUE    = 3'd3,
    RESP     = 3'd4
  } state_e;

  // Latched command, already reshaped into transfer-request form.
  typedef struct packed {
    logic [2:0]  attr;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic        cp;
    logic [2:0]  mode;
    logic        rnw;
    logic        wroc;
    logic        toc;
    logic [15:0] len;
    logic [31:0] data;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [DatAw-1:0] dat_addr_q;
  logic             oob_q;
  logic             drop_q;
  logic [6:0]       xfer_addr_q;
  logic             xfer_i2c_q;
  logic [31:0]      resp_desc_q;

  logic             accept;
  logic             resp_set;
  logic [3:0]       resp_err;
  logic [3:0]       resp_tid;
  logic             addr_set;

  // Incoming descriptor fields used for the accept-time decision.
  logic [2:0] attr_in;
  logic [3:0] mipi_in;
  logic [4:0] dev_idx_in;
  logic       rnw_in;
  logic       wroc_in;

  assign attr_in    = cmd_desc_i[2:0];
  assign mipi_in    = cmd_desc_i[11:8];
  assign dev_idx_in = cmd_desc_i[20:16];
  assign rnw_in     = cmd_desc_i[29];
  assign wroc_in    = cmd_desc_i[30];

  assign accept   = (state_q == IDLE) && cmd_valid_i;
  // Responses raised straight from IDLE take the tid from the live descriptor.
  assign resp_tid = (state_q == IDLE) ? cmd_desc_i[6:3] : cmd_q.tid;

  // Immediate commands carry their byte count in dtt and up to four data
  // bytes in DWORD1; regular/combo carry a 16-bit length and def_byte/offset.
  always_comb begin
    cmd_d      = '0;
    cmd_d.attr = attr_in;
    cmd_d.tid  = cmd_desc_i[6:3];
    cmd_d.cmd  = cmd_desc_i[14:7];
    cmd_d.cp   = cmd_desc_i[15];
    cmd_d.mode = cmd_desc_i[28:26];
    cmd_d.rnw  = rnw_in;
    cmd_d.wroc = wroc_in;
    cmd_d.toc  = cmd_desc_i[31];
    if (attr_in == AttrImmediate) begin
      cmd_d.len  = {13'd0, cmd_desc_i[25:23]};
      cmd_d.data = cmd_desc_i[63:32];
    end else begin
      cmd_d.len  = cmd_desc_i[63:48];
      cmd_d.data = {16'h0, cmd_desc_i[47:32]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    resp_set = 1'b0;
    resp_err = ErrSuccess;
    addr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          case (attr_in)
            AttrRegular, AttrCombo: state_d = DAT_REQ;
            AttrImmediate: begin
              if (rnw_in) begin
                state_d  = RESP;
                resp_set = 1'b1;
                resp_err = ErrNotSupp;
              end else begin
                state_d = DAT_REQ;
              end
            end
            AttrInternal: begin
              if (mipi_in != MipiNoop) begin
                state_d  = RESP;
                resp_set = 1'b1;
                resp_err = ErrNotSupp;
              end else if (wroc_in) begin
                state_d  = RESP;
                resp_set = 1'b1;
                resp_err = ErrSuccess;
              end
              // Noop without wroc completes silently.
            end
            default: begin
              // AddressAssignment and undefined attributes.
              state_d  = RESP;
              resp_set = 1'b1;
              resp_err = ErrNotSupp;
            end
          endcase
        end
      end
      DAT_REQ: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (oob_q) begin
          state_d  = RESP;
          resp_set = 1'b1;
          resp_err = ErrNack;
        end else begin
          state_d = DAT_WAIT;
        end
      end
      DAT_WAIT: begin
        // The read cannot be cancelled, so an abort here waits for the data
        // and throws it away.
        if (dat_rvalid_i) begin
          if (drop_q || abort_i) begin
            state_d = IDLE;
          end else if (dat_rerror_i != 2'b00) begin
            state_d  = RESP;
            resp_set = 1'b1;
            resp_err = ErrHcAborted;
          end else begin
            state_d  = ISSUE;
            addr_set = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (xfer_ready_i || abort_i) state_d = IDLE;
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q       <= '0;
      dat_addr_q  <= '0;
      oob_q       <= 1'b0;
      drop_q      <= 1'b0;
      xfer_addr_q <= '0;
      xfer_i2c_q  <= 1'b0;
      resp_desc_q <= '0;
    end else begin
      if (accept) begin
        cmd_q      <= cmd_d;
        dat_addr_q <= dev_idx_in[DatAw-1:0];
        oob_q      <= int'(dev_idx_in) >= DatDepth;
      end
      // Bit 31 of the DAT entry marks a legacy I2C device with a static
      // address in [6:0]; otherwise the dynamic address lives in [22:16].
      if (addr_set) begin
        xfer_i2c_q  <= dat_rdata_i[31];
        xfer_addr_q <= dat_rdata_i[31] ? dat_rdata_i[6:0] : dat_rdata_i[22:16];
      end
      if (resp_set) resp_desc_q <= {resp_err, resp_tid, 24'h0};
      drop_q <= (state_q == DAT_WAIT) && !dat_rvalid_i && (drop_q || abort_i);
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign idle_o       = (state_q == IDLE);
  assign dat_req_o    = (state_q == DAT_REQ) && !oob_q;
  assign dat_addr_o   = dat_addr_q;
  assign xfer_valid_o = (state_q == ISSUE);
  assign resp_valid_o = (state_q == RESP);
  assign resp_desc_o  = resp_desc_q;

  assign xfer_attr_o = cmd_q.attr;
  assign xfer_tid_o  = cmd_q.tid;
  assign xfer_addr_o = xfer_addr_q;
  assign xfer_i2c_o  = xfer_i2c_q;
  assign xfer_rnw_o  = cmd_q.rnw;
  assign xfer_mode_o = cmd_q.mode;
  assign xfer_cp_o   = cmd_q.cp;
  assign xfer_cmd_o  = cmd_q.cmd;
  assign xfer_len_o  = cmd_q.len;
  assign xfer_data_o = cmd_q.data;
  assign xfer_toc_o  = cmd_q.toc;
  assign xfer_wroc_o = cmd_q.wroc;

  // Reserved descriptor bits and DAT entry fields this block does not use.
  logic unused_bits;
  assign unused_bits = ^{cmd_desc_i[22:21], dat_rdata_i};

endmodule

// File: tb/tb_i3c_cmd_dispatch.sv
// Randomised bench for i3c_cmd_dispatch: each command is driven to
// completion while the bench plays the DAT memory, then the observed
// request/transfer/response is compared with a descriptor-level model.
module tb_i3c_cmd_dispatch;
  localparam int DatDepth = 16;
  localparam int DatWidth = 64;
  localparam int DatAw    = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                cmd_valid_i = 1'b0;
  logic                cmd_ready_o;
  logic [63:0]         cmd_desc_i = '0;
  logic                dat_req_o;
  logic [DatAw-1:0]    dat_addr_o;
  logic                dat_rvalid_i = 1'b0;
  logic [DatWidth-1:0] dat_rdata_i = '0;
  logic [1:0]          dat_rerror_i = '0;
  logic                xfer_valid_o;
  logic                xfer_ready_i = 1'b0;
  logic [2:0]          xfer_attr_o;
  logic [3:0]          xfer_tid_o;
  logic [6:0]          xfer_addr_o;
  logic                xfer_i2c_o;
  logic                xfer_rnw_o;
  logic [2:0]          xfer_mode_o;
  logic                xfer_cp_o;
  logic [7:0]          xfer_cmd_o;
  logic [15:0]         xfer_len_o;
  logic [31:0]         xfer_data_o;
  logic                xfer_toc_o;
  logic                xfer_wroc_o;
  logic                resp_valid_o;
  logic                resp_ready_i = 1'b0;
  logic [31:0]         resp_desc_o;
  logic                abort_i = 1'b0;
  logic                idle_o;

  always #5 clk_i = ~clk_i;

  i3c_cmd_dispatch #(.DatDepth(DatDepth), .DatWidth(DatWidth)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_desc_i(cmd_desc_i),
    .dat_req_o(dat_req_o), .dat_addr_o(dat_addr_o),
    .dat_rvalid_i(dat_rvalid_i), .dat_rdata_i(dat_rdata_i), .dat_rerror_i(dat_rerror_i),
    .xfer_valid_o(xfer_valid_o), .xfer_ready_i(xfer_ready_i),
    .xfer_attr_o(xfer_attr_o), .xfer_tid_o(xfer_tid_o), .xfer_addr_o(xfer_addr_o),
    .xfer_i2c_o(xfer_i2c_o), .xfer_rnw_o(xfer_rnw_o), .xfer_mode_o(xfer_mode_o),
    .xfer_cp_o(xfer_cp_o), .xfer_cmd_o(xfer_cmd_o), .xfer_len_o(xfer_len_o),
    .xfer_data_o(xfer_data_o), .xfer_toc_o(xfer_toc_o), .xfer_wroc_o(xfer_wroc_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_desc_o(resp_desc_o),
    .abort_i(abort_i), .idle_o(idle_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] dat_mem [DatDepth];

  // Observations of the last command.
  int               o_nreq, o_xcyc, o_rcyc, o_done;
  logic [DatAw-1:0] o_raddr;
  logic             o_xfer, o_resp, o_stable;
  logic [77:0]      o_xf;
  logic [31:0]      o_rdesc;

  function automatic logic [77:0] xf_now();
    return {xfer_attr_o, xfer_tid_o, xfer_addr_o, xfer_i2c_o, xfer_rnw_o, xfer_mode_o,
            xfer_cp_o, xfer_cmd_o, xfer_len_o, xfer_data_o, xfer_toc_o, xfer_wroc_o};
  endfunction

  // Called at a sample point (1 time unit after a rising edge) with the DUT
  // idle. Cycle 0 is the command handshake; runs until idle_o returns.
  task automatic run_cmd(input logic [63:0] d, input int lat, input logic [1:0] rerr,
                         input int xdly, input int rdly, input int abort_at, input bit spur);
    int req_cyc;
    o_nreq = 0; o_xfer = 0; o_resp = 0; o_stable = 1; o_xcyc = -1; o_rcyc = -1;
    o_done = 0; o_raddr = '0; o_xf = '0; o_rdesc = '0; req_cyc = -1;
    chk("cmd_ready_at_start", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_desc_i  = d;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk_i); #1;
      cmd_valid_i = 0; dat_rvalid_i = 0; dat_rerror_i = 0; xfer_ready_i = 0;
      resp_ready_i = 0; abort_i = 0;
      if (idle_o) begin o_done = k; break; end
      if (dat_req_o) begin o_nreq++; o_raddr = dat_addr_o; req_cyc = k; end
      if (req_cyc > 0 && k == req_cyc + lat) begin
        dat_rvalid_i = 1; dat_rdata_i = dat_mem[o_raddr]; dat_rerror_i = rerr;
      end else if (spur && k == 1) begin
        dat_rvalid_i = 1; dat_rdata_i = {$urandom, $urandom};
      end
      if (xfer_valid_o) begin
        if (!o_xfer) begin o_xfer = 1; o_xcyc = k; o_xf = xf_now(); end
        else if (xf_now() !== o_xf) o_stable = 0;
        if (k >= o_xcyc + xdly) xfer_ready_i = 1;
      end
      if (resp_valid_o) begin
        if (!o_resp) begin o_resp = 1; o_rcyc = k; o_rdesc = resp_desc_o; end
        else if (resp_desc_o !== o_rdesc) o_stable = 0;
        if (k >= o_rcyc + rdly) resp_ready_i = 1;
      end
      if (k == abort_at) abort_i = 1;
    end
    chk("cmd_completes", o_done != 0, 1);
  endtask

  // Reference: what a non-aborted command must produce, from descriptor rules.
  task automatic expect_cmd(input logic [63:0] d, input logic [1:0] rerr, input int lat);
    logic [2:0] a; logic [3:0] tid; int idx; bit need_dat; int kind; logic [3:0] err;
    int ecyc; logic [63:0] e; logic [77:0] exf; logic [15:0] len; logic [31:0] data;
    a = d[2:0]; tid = d[6:3]; idx = int'(d[20:16]);
    need_dat = (a == 3'd0) || (a == 3'd3) || (a == 3'd1 && !d[29]);
    err = 4'h0; kind = 0; ecyc = 1;
    if (need_dat) begin
      if (idx >= DatDepth)  begin kind = 2; err = 4'h5; ecyc = 2; end
      else if (rerr != 0)   begin kind = 2; err = 4'h8; ecyc = lat + 2; end
      else                  begin kind = 1; ecyc = lat + 2; end
    end else if (a == 3'd7 && d[11:8] == 4'h0) begin
      kind = d[30] ? 2 : 0;
    end else begin
      kind = 2; err = 4'hA;
    end
    chk("dat_req_count", o_nreq, (need_dat && idx < DatDepth) ? 1 : 0);
    if (o_nreq > 0) chk("dat_addr", o_raddr, idx);
    chk("xfer_seen", o_xfer, kind == 1);
    chk("resp_seen", o_resp, kind == 2);
    if (kind == 1 && o_xfer) begin
      e = dat_mem[idx];
      if (a == 3'd1) begin len = {13'd0, d[25:23]}; data = d[63:32]; end
      else           begin len = d[63:48]; data = {16'h0, d[47:32]}; end
      exf = {a, tid, (e[31] ? e[6:0] : e[22:16]), e[31], d[29], d[28:26], d[15], d[14:7],
             len, data, d[31], d[30]};
      chk("xfer_addr", o_xf[70:64], exf[70:64]);
      chk("xfer_i2c", o_xf[63], e[31]);
      chk("xfer_len", o_xf[49:34], len);
      chk("xfer_data", o_xf[33:2], data);
      chk("xfer_fields_hi", o_xf[77:64], exf[77:64]);
      chk("xfer_fields_lo", o_xf[63:0], exf[63:0]);
      chk("xfer_cycle", o_xcyc, ecyc);
    end
    if (kind == 2 && o_resp) begin
      chk("resp_desc", o_rdesc, {err, tid, 24'h0});
      chk("resp_cycle", o_rcyc, ecyc);
    end
    chk("hold_stable", o_stable, 1);
    chk("cmd_ready_back", cmd_ready_o, 1);
  endtask

  function automatic logic [63:0] mk(input logic [2:0] a, input logic [3:0] tid, input logic [4:0] idx);
    logic [63:0] d;
    d = '0; d[2:0] = a; d[6:3] = tid; d[20:16] = idx;
    return d;
  endfunction

  function automatic logic [63:0] rand_desc();
    logic [63:0] d; logic [2:0] a;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0, 1, 2: a = 3'd0;
      3, 4:    a = 3'd1;
      5:       a = 3'd2;
      6:       a = 3'd3;
      7:       a = 3'd7;
      default: a = 3'($urandom_range(4, 7));
    endcase
    d[2:0] = a;
    if (a == 3'd7 && $urandom_range(0, 1) == 1) d[11:8] = 4'h0;
    d[20:16] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    return d;
  endfunction

  task automatic check_reset_vals(input string tag);
    logic [77:0] xf;
    xf = xf_now();
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    chk({tag, "_idle"}, idle_o, 1);
    chk({tag, "_dat_req"}, dat_req_o, 0);
    chk({tag, "_dat_addr"}, dat_addr_o, 0);
    chk({tag, "_xfer_valid"}, xfer_valid_o, 0);
    chk({tag, "_xfer_hi"}, xf[77:64], 0);
    chk({tag, "_xfer_lo"}, xf[63:0], 0);
    chk({tag, "_resp_valid"}, resp_valid_o, 0);
    chk({tag, "_resp_desc"}, resp_desc_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d; logic [1:0] rerr; int lat; bit seen, req;
    for (int i = 0; i < DatDepth; i++) dat_mem[i] = {$urandom, $urandom};
    #2;
    check_reset_vals("reset");
    #10 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Regular I3C write.
    dat_mem[2] = 64'h0000_0000_0052_0000;
    d = mk(3'd0, 4'd3, 5'd2); d[63:48] = 16'h0010;
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0);
    expect_cmd(d, 2'b00, 1);
    chk("t1_addr", o_xf[70:64], 7'h52);

    // Immediate write to an I2C device.
    dat_mem[5] = 64'h0000_0000_8000_0050;
    d = mk(3'd1, 4'd9, 5'd5); d[25:23] = 3'd3; d[63:32] = 32'hAABBCCDD;
    run_cmd(d, 1, 2'b00, 2, 0, 0, 0);
    expect_cmd(d, 2'b00, 1);

    // Rejections.
    d = mk(3'd2, 4'd5, 5'd1);
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);
    chk("t3_addr_assign", o_rdesc, 32'hA500_0000);
    d = mk(3'd1, 4'd6, 5'd1); d[29] = 1'b1;
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);
    chk("t3_imm_read", o_rdesc, 32'hA600_0000);
    d = mk(3'd0, 4'd7, 5'd20);
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);
    chk("t3_idx20", o_rdesc, 32'h5700_0000);
    d = mk(3'd3, 4'd2, 5'd16);
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);
    d = mk(3'd3, 4'd2, 5'd15);
    run_cmd(d, 2, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 2);

    // Noop and DAT error.
    d = mk(3'd7, 4'd1, 5'd0); d[30] = 1'b1;
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);
    chk("t4_noop_wroc", o_rdesc, 32'h0100_0000);
    d = mk(3'd7, 4'd1, 5'd0);
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);
    chk("t4_noop_done", o_done, 1);
    d = mk(3'd0, 4'd4, 5'd3);
    run_cmd(d, 1, 2'b01, 0, 3, 0, 0); expect_cmd(d, 2'b01, 1);

    // Abort in DAT_WAIT, data arrives 5 cycles later.
    d = mk(3'd0, 4'd8, 5'd2);
    run_cmd(d, 6, 2'b00, 0, 0, 2, 0);
    chk("abort_wait_xfer", o_xfer, 0);
    chk("abort_wait_resp", o_resp, 0);
    chk("abort_wait_done", o_done, 8);
    // Abort in ISSUE and in DAT_REQ.
    run_cmd(d, 1, 2'b00, 5, 0, 4, 0);
    chk("abort_issue_done", o_done, 5);
    chk("abort_issue_resp", o_resp, 0);
    run_cmd(d, 1, 2'b00, 0, 0, 1, 0);
    chk("abort_req_done", o_done, 2);
    chk("abort_req_xfer", o_xfer, 0);
    // Abort while a response is pending is ignored.
    d = mk(3'd2, 4'd5, 5'd1);
    run_cmd(d, 1, 2'b00, 0, 3, 1, 0);
    chk("abort_resp_kept", o_rdesc, 32'hA500_0000);

    // Backpressure on the transfer request.
    d = mk(3'd0, 4'd3, 5'd2); d[63:48] = 16'h1234; d[47:32] = 16'h00EE; d[31] = 1'b1;
    run_cmd(d, 1, 2'b00, 10, 0, 0, 0); expect_cmd(d, 2'b00, 1);

    // Reset while in ISSUE.
    d = mk(3'd0, 4'd3, 5'd2); d[63:48] = 16'h0010;
    cmd_valid_i = 1'b1; cmd_desc_i = d; req = 0; seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i); #1;
      cmd_valid_i = 0; dat_rvalid_i = 0;
      if (xfer_valid_o) begin seen = 1; break; end
      if (req) begin dat_rvalid_i = 1; dat_rdata_i = dat_mem[2]; dat_rerror_i = 0; end
      if (dat_req_o) req = 1;
    end
    chk("rst_issue_reached", seen, 1);
    #3 rst_ni = 1'b0;
    #1 check_reset_vals("midrst");
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_cmd(d, 1, 2'b00, 0, 0, 0, 0); expect_cmd(d, 2'b00, 1);

    // Randomised traffic.
    for (int i = 0; i < 150; i++) begin
      d    = rand_desc();
      lat  = $urandom_range(1, 4);
      rerr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_cmd(d, lat, rerr, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
      expect_cmd(d, rerr, lat);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
